// File: rtl/seq_divider.sv
// Sequential unsigned restoring divider, one quotient bit per clock.
// Zero divisors complete on the accepting edge with div_by_zero set.
module seq_divider #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] dividend,
  input  logic [N-1:0] divisor,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] quotient,
  output logic [N-1:0] remainder,
  output logic         div_by_zero
);

  localparam int CW = $clog2(N + 1);

  typedef enum logic {
    S_IDLE,
    S_CALC
  } state_t;

  state_t        r_state;
  logic [N-1:0]  r_d;
  logic [N-1:0]  r_v;
  logic [N-1:0]  r_r;
  logic [CW-1:0] r_c;
  logic          r_done;
  logic          r_dbz;
  logic [N-1:0]  r_q;
  logic [N-1:0]  r_rem;

  // T carries the shifted-out top bit of R only for the compare;
  // after a subtraction the result always fits back in N bits.
  logic [N:0]    w_t;
  logic          w_ge;
  logic [N-1:0]  w_rnext;
  logic [N-1:0]  w_dnext;
  logic          w_last;

  assign w_t     = {r_r, r_d[N-1]};
  assign w_ge    = (w_t >= {1'b0, r_v});
  assign w_rnext = w_ge ? (w_t[N-1:0] - r_v) : w_t[N-1:0];
  assign w_dnext = {r_d[N-2:0], w_ge};
  assign w_last  = (r_c == CW'(N - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_d     <= '0;
      r_v     <= '0;
      r_r     <= '0;
      r_c     <= '0;
      r_done  <= 1'b0;
      r_dbz   <= 1'b0;
      r_q     <= '0;
      r_rem   <= '0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (start) begin
            if (divisor != '0) begin
              r_d     <= dividend;
              r_v     <= divisor;
              r_r     <= '0;
              r_c     <= '0;
              r_state <= S_CALC;
            end else begin
              r_q    <= '1;
              r_rem  <= dividend;
              r_dbz  <= 1'b1;
              r_done <= 1'b1;
            end
          end
        end
        S_CALC: begin
          r_r <= w_rnext;
          r_d <= w_dnext;
          r_c <= r_c + CW'(1);
          if (w_last) begin
            r_q     <= w_dnext;
            r_rem   <= w_rnext;
            r_dbz   <= 1'b0;
            r_done  <= 1'b1;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy        = (r_state == S_CALC);
  assign done        = r_done;
  assign quotient    = r_q;
  assign remainder   = r_rem;
  assign div_by_zero = r_dbz;

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: cycle model plus directed
// operations with hand-computed results and an exhaustive N=4 sweep.
module tb_seq_divider;

  localparam int N = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [N-1:0] dividend = '0;
  logic [N-1:0] divisor = '0;
  logic         busy;
  logic         done;
  logic [N-1:0] quotient;
  logic [N-1:0] remainder;
  logic         div_by_zero;

  int n_cmp = 0;
  int n_bad = 0;

  seq_divider #(.N(N)) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .dividend(dividend),
    .divisor(divisor),
    .busy(busy),
    .done(done),
    .quotient(quotient),
    .remainder(remainder),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  // Model: an accepted op finishes N edges later with a/b and a%b;
  // a zero divisor finishes on the accepting edge.
  int           m_left = 0;
  logic [N-1:0] m_pq = '0;
  logic [N-1:0] m_pr = '0;
  logic [N-1:0] e_q = '0;
  logic [N-1:0] e_r = '0;
  logic         e_done = 1'b0;
  logic         e_dbz = 1'b0;
  logic         e_busy = 1'b0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_left <= 0;
      e_q    <= '0;
      e_r    <= '0;
      e_dbz  <= 1'b0;
      e_done <= 1'b0;
      e_busy <= 1'b0;
    end else if (m_left > 0) begin
      m_left <= m_left - 1;
      e_done <= (m_left == 1);
      e_busy <= (m_left != 1);
      if (m_left == 1) begin
        e_q   <= m_pq;
        e_r   <= m_pr;
        e_dbz <= 1'b0;
      end
    end else begin
      e_done <= 1'b0;
      e_busy <= 1'b0;
      if (start) begin
        if (divisor == '0) begin
          e_q    <= '1;
          e_r    <= dividend;
          e_dbz  <= 1'b1;
          e_done <= 1'b1;
        end else begin
          m_pq   <= dividend / divisor;
          m_pr   <= dividend % divisor;
          m_left <= N;
          e_busy <= 1'b1;
        end
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t",
               name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("busy", int'(busy), int'(e_busy));
    chk("done", int'(done), int'(e_done));
    chk("quotient", int'(quotient), int'(e_q));
    chk("remainder", int'(remainder), int'(e_r));
    chk("div_by_zero", int'(div_by_zero), int'(e_dbz));
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic do_op(input int a, input int b, input int eq,
                       input int er, input int edz, input int elat);
    int lat;
    int nb;
    lat = 0;
    nb = 0;
    start = 1'b1;
    dividend = N'(a);
    divisor = N'(b);
    @(posedge clk);
    #1;
    start = 1'b0;
    if (busy) nb++;
    while (!done && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
      if (busy) nb++;
    end
    #1;
    chk("latency", lat, elat);
    chk("busy_cycles", nb, elat);
    chk("op_quotient", int'(quotient), eq);
    chk("op_remainder", int'(remainder), er);
    chk("op_dbz", int'(div_by_zero), edz);
  endtask

  initial begin
    int nd;
    repeat (2) step();
    rst = 1'b0;
    step();

    do_op(13, 3, 4, 1, 0, 4);
    do_op(15, 1, 15, 0, 0, 4);
    do_op(15, 15, 1, 0, 0, 4);
    do_op(0, 5, 0, 0, 0, 4);
    do_op(5, 9, 0, 5, 0, 4);
    step();
    do_op(7, 0, 15, 7, 1, 0);
    do_op(9, 2, 4, 1, 0, 4);
    step();

    do_op(14, 4, 3, 2, 0, 4);
    do_op(11, 2, 5, 1, 0, 4);
    step();

    // A second start mid-operation must be ignored entirely.
    start = 1'b1;
    dividend = 4'd12;
    divisor = 4'd5;
    step();
    start = 1'b0;
    step();
    start = 1'b1;
    dividend = 4'd1;
    divisor = 4'd1;
    step();
    start = 1'b0;
    dividend = '0;
    divisor = '0;
    nd = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      if (done) begin
        nd++;
        chk("ign_quotient", int'(quotient), 2);
        chk("ign_remainder", int'(remainder), 2);
      end
    end
    #1;
    chk("ign_done_count", nd, 1);

    // Reset in the middle of 10/3.
    start = 1'b1;
    dividend = 4'd10;
    divisor = 4'd3;
    step();
    start = 1'b0;
    step();
    step();
    rst = 1'b1;
    #1;
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_quotient", int'(quotient), 0);
    chk("rst_remainder", int'(remainder), 0);
    chk("rst_dbz", int'(div_by_zero), 0);
    #1;
    repeat (2) step();
    rst = 1'b0;
    nd = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      if (done) nd++;
    end
    #1;
    chk("rst_no_done", nd, 0);
    do_op(10, 3, 3, 1, 0, 4);

    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        if (b == 0) do_op(a, b, 15, a, 1, 0);
        else do_op(a, b, a / b, a % b, 0, N);
      end
    end

    step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
